io_port: RTL
============

# io_port

Memory-mapped I/O endpoint on the RAM/IO side of the CPU memory bus (`mem_a`/`mem_dout`/`mem_wr`/`mem_din`).
- Decodes accesses with `mem_a[17:16]==2'b11`.
- Buffers output bytes in a TX FIFO that drains to the UART transmitter, and drives `io_buffer_full` back to the CPU.
- Serves input-byte reads and cycle-counter reads.
- Sequences the program-stop handshake.

## Interface
Parameters:
- `DEPTH_LOG2`, 4 — TX FIFO depth is 2^DEPTH_LOG2 entries.
- `FULL_SLACK`, 2 — `io_buffer_full` asserts when free entries ≤ FULL_SLACK, which absorbs writes already in flight.

Ports:
- `clk_in` in 1 — system clock; the block's only clock.
- `rst_in` in 1 — reset, synchronous, active-low.
- `rdy_in` in 1 — CPU ready; bus accesses are ignored while low.
- `io_a` in 18 — bus address (`mem_a[17:0]`).
- `io_wr` in 1 — 1 = write.
- `io_wdata` in 8 — CPU write byte.
- `io_rdata` out 8 — read byte, valid one cycle after the request.
- `io_buffer_full` out 1 — backpressure to the CPU.
- `rx_empty` in 1 — UART RX FIFO empty.
- `rx_data` in 8 — UART RX head byte.
- `rx_pop` out 1 — pops RX head; one-cycle pulse.
- `tx_valid` out 1 — TX byte available.
- `tx_data` out 8 — TX byte.
- `tx_ready` in 1 — UART accepts when `tx_valid & tx_ready`.
- `prog_stop` out 1 — held high once HALT is reached.
- `tx_ovf` out 1 — sticky; set when a push arrives at a truly full FIFO.

## Operation
- Access decode: an I/O access needs `io_sel = (io_a[17:16]==2'b11) & rdy_in`. Offset is `io_a[2:0]`.
- Write to 0x30000:
  - Non-zero byte: pushed to the TX FIFO.
  - 0x00: ignored.
  - FIFO truly full: byte dropped and `tx_ovf` set.
- Write to 0x30004: requests stop; FSM goes RUN→DRAIN. The data byte is ignored.
- Writes at any other offset are ignored.
- Read of 0x30000:
  - Next cycle `io_rdata = rx_data`, and `rx_pop` pulses in the request cycle.
  - If `rx_empty`, returns 0x00 and no pop.
- Read of 0x30004–0x30007:
  - A read at 0x30004 snapshots the 32-bit cycle counter.
  - Offset k returns byte k of the snapshot (little-endian).
  - Offsets 5–7 return the existing snapshot; no re-snapshot.
- Cycle counter: 32-bit, +1 every cycle after reset, including while `rdy_in` is low. Wraps 0xFFFFFFFF→0.
- TX FIFO: circular buffer with `DEPTH_LOG2`-bit pointers and a (DEPTH_LOG2+1)-bit count.
  - Head presented on `tx_data` with `tx_valid = count!=0`.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Draining continues regardless of `rdy_in`.
- `io_buffer_full = (count >= 2^DEPTH_LOG2 − FULL_SLACK) | state!=RUN`.
- FSM states:
  - RUN: normal operation.
  - DRAIN: new TX pushes are dropped without setting `tx_ovf`. Moves to STOPCHR when count==0.
  - STOPCHR: drives `tx_valid=1`, `tx_data=0x00`. Moves to HALT on `tx_ready`.
  - HALT: terminal. `prog_stop=1`, `tx_valid=0`, reads still served.
- Reset while in any state: returns to RUN, FIFO emptied, counter = 0.

## Timing
- Reset values:
  - `io_rdata`=0, `rx_pop`=0, `tx_valid`=0, `tx_data`=0.
  - `io_buffer_full`=0, `prog_stop`=0, `tx_ovf`=0.
  - Counter=0, snapshot=0, FSM=RUN.
- Read latency: 1 cycle. A request at edge N yields `io_rdata` after edge N+1, held until the next read.
- `rx_pop` is registered in the same edge as the request.
- Write-to-`tx_valid` latency: 1 cycle when the FIFO was empty.
- `io_buffer_full` is registered and reflects count after the current edge.
- One TX byte per cycle maximum.

## Configuration
- `IO_CYCLE_COUNTER_EN`:
  - Defined: counter and snapshot registers are present; offsets 4–7 read the snapshot bytes.
  - Undefined: no counter logic; reads at offsets 4–7 return 0x00. The stop write at 0x30004 still functions.

## Structure
- Shared package (`utils.v` defines):
  - `IO_BASE_SEL` (2'b11).
  - Offsets `IO_OFF_DATA` (0) and `IO_OFF_STOP` (4).
  - FSM state encodings `IO_ST_RUN` / `IO_ST_DRAIN` / `IO_ST_STOPCHR` / `IO_ST_HALT`.
- Sub-module `io_tx_fifo` holds the parameterised byte FIFO (push, pop, count, full/empty).
- `io_port` holds decode, counter, read mux and FSM.

## Test plan
- Reset, then write 'A','B','C' to 0x30000 with `tx_ready=1` → `tx_data` = 0x41, 0x42, 0x43 on consecutive cycles starting 1 cycle after the first write; `tx_ovf`=0.
- Write 0x00 to 0x30000 → no push; `tx_valid` stays 0.
- `tx_ready=0`, DEPTH 16, 14 writes → `io_buffer_full` rises after the 14th; writes 15 and 16 accepted; the 17th is dropped and `tx_ovf`=1.
- Counter at 0x12345678; read 0x30004–0x30007 on consecutive cycles → `io_rdata` 0x78, 0x56, 0x34, 0x12 from the snapshot. Without `IO_CYCLE_COUNTER_EN` → all 0x00.
- 3 bytes queued, `tx_ready=0`, then write 0x30004; release `tx_ready` → the 3 bytes, then 0x00, then `prog_stop=1` the cycle after the 0x00 handshake. A write during DRAIN is not transmitted.
- Assert reset while in DRAIN with 2 bytes queued → next cycle `tx_valid=0`, FSM RUN, `io_buffer_full=0`, counter 0.

Source files
------------

// File: rtl/io_port_pkg.sv
// io_port_pkg
//   Shared constants for the memory-mapped I/O endpoint:
//   - bus decode value for mem_a[17:16]
//   - register offsets within the I/O window
//   - stop-sequence FSM state encodings
//   - bus request struct and a byte-select helper for the cycle snapshot
package io_port_pkg;

  // I/O window select on mem_a[17:16]
  localparam logic [1:0] IO_BASE_SEL   = 2'b11;

  // Offsets inside the window (mem_a[2:0])
  localparam logic [2:0] IO_OFF_DATA   = 3'd0;
  localparam logic [2:0] IO_OFF_STOP   = 3'd4;

  // Stop-sequence states
  localparam logic [1:0] IO_ST_RUN     = 2'd0;
  localparam logic [1:0] IO_ST_DRAIN   = 2'd1;
  localparam logic [1:0] IO_ST_STOPCHR = 2'd2;
  localparam logic [1:0] IO_ST_HALT    = 2'd3;

  // Decoded bus access for one cycle
  typedef struct packed {
    logic       vld;   // I/O window hit with CPU ready
    logic       wr;    // 1 = write
    logic [2:0] off;   // register offset
    logic [7:0] data;  // write byte
  } io_req_t;

  // Little-endian byte k of a 32-bit word
  function automatic logic [7:0] snap_byte(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// io_tx_fifo
//   Circular byte FIFO feeding the UART transmitter.
//   Ports:
//     clk_in, rst_in  - clock, synchronous active-low reset (empties the FIFO)
//     push, push_data - enqueue request; ignored when full
//     pop             - dequeue request; ignored when empty
//     head            - oldest entry (meaningful only when !empty)
//     count           - current occupancy (DEPTH_LOG2+1 bits)
//     count_nxt       - occupancy after the current edge
//     full, empty     - occupancy flags from the registered count
module io_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   count_nxt,
  output logic                  full,
  output logic                  empty
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  // "Full" is judged on the registered count, so a push into a full FIFO is
  // dropped even if a pop happens on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop  & ~empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/io_port.sv
// io_port
//   Memory-mapped I/O endpoint on the RAM/IO side of the CPU bus.
//   Window: io_a[17:16]==2'b11, offset io_a[2:0].
//     wr 0 : push non-zero byte to TX FIFO (0x00 ignored, overflow sets tx_ovf)
//     wr 4 : request program stop (RUN -> DRAIN -> STOPCHR -> HALT)
//     rd 0 : pop one byte from UART RX (0x00 when RX empty)
//     rd 4 : snapshot cycle counter, return byte 0; rd 5..7 return bytes 1..3
//   Optional: IO_CYCLE_COUNTER_EN adds the 32-bit cycle counter and snapshot;
//   without it reads at offsets 4..7 return 0x00.
//   Ports:
//     clk_in, rst_in   - clock, synchronous active-low reset
//     rdy_in           - CPU ready; bus accesses ignored while low
//     io_a, io_wr, io_wdata, io_rdata - CPU bus (read data one cycle later)
//     io_buffer_full   - registered backpressure to the CPU
//     rx_empty, rx_data, rx_pop       - UART RX FIFO interface
//     tx_valid, tx_data, tx_ready     - UART TX handshake
//     prog_stop        - high once HALT is reached
//     tx_ovf           - sticky TX overflow flag
module io_port
  import io_port_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int FULL_SLACK = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [17:0] io_a,
  input  logic        io_wr,
  input  logic [7:0]  io_wdata,
  output logic [7:0]  io_rdata,
  output logic        io_buffer_full,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        prog_stop,
  output logic        tx_ovf
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  // Threshold leaves FULL_SLACK entries for writes already in flight.
  localparam logic [DEPTH_LOG2:0] FULL_TH = (DEPTH_LOG2+1)'(DEPTH - FULL_SLACK);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  io_req_t req;
  logic    wr_data, wr_stop, rd_any, rd_data;

  assign req.vld  = (io_a[17:16] == IO_BASE_SEL) & rdy_in;
  assign req.wr   = io_wr;
  assign req.off  = io_a[2:0];
  assign req.data = io_wdata;

  assign wr_data = req.vld &  req.wr & (req.off == IO_OFF_DATA);
  assign wr_stop = req.vld &  req.wr & (req.off == IO_OFF_STOP);
  assign rd_any  = req.vld & ~req.wr;
  assign rd_data = rd_any  & (req.off == IO_OFF_DATA);

  // Only offset bits [2:0] participate in the decode.
  logic unused_addr;
  assign unused_addr = ^io_a[15:3];

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic                  drain_en;
  logic                  push_req, fifo_pop;
  logic [7:0]            f_head;
  logic [DEPTH_LOG2:0]   f_count, f_count_nxt;
  logic                  f_full, f_empty;

  // FIFO keeps draining in RUN and DRAIN, independent of rdy_in.
  assign drain_en = (state_q == IO_ST_RUN) | (state_q == IO_ST_DRAIN);
  // New bytes are accepted only in RUN; DRAIN drops them silently.
  assign push_req = wr_data & (req.data != 8'h00) & (state_q == IO_ST_RUN);
  assign fifo_pop = drain_en & ~f_empty & tx_ready;

  io_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (push_req),
    .push_data (req.data),
    .pop       (fifo_pop),
    .head      (f_head),
    .count     (f_count),
    .count_nxt (f_count_nxt),
    .full      (f_full),
    .empty     (f_empty)
  );

  // ---------------------------------------------------------------------------
  // Stop-sequence FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IO_ST_RUN:     if (wr_stop)  state_d = IO_ST_DRAIN;
      IO_ST_DRAIN:   if (f_empty)  state_d = IO_ST_STOPCHR;
      IO_ST_STOPCHR: if (tx_ready) state_d = IO_ST_HALT;
      default:                     state_d = IO_ST_HALT;
    endcase
  end

  // TX output: FIFO head while draining, a single 0x00 terminator in STOPCHR,
  // silent in HALT. tx_data is forced to 0 when not valid.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      IO_ST_RUN, IO_ST_DRAIN: begin
        tx_valid = ~f_empty;
        tx_data  = f_empty ? 8'h00 : f_head;
      end
      IO_ST_STOPCHR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h00;
      end
      default: ;
    endcase
  end

  assign prog_stop = (state_q == IO_ST_HALT);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q        <= IO_ST_RUN;
      io_buffer_full <= 1'b0;
      tx_ovf         <= 1'b0;
    end else begin
      state_q        <= state_d;
      // Registered from next-state values so it reflects the count after this edge.
      io_buffer_full <= (f_count_nxt >= FULL_TH) | (state_d != IO_ST_RUN);
      if (push_req & f_full) tx_ovf <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter (optional)
  // ---------------------------------------------------------------------------
`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] cyc_cnt, cyc_snap;

  // Free-running; counts even while the CPU is stalled.
  always_ff @(posedge clk_in) begin
    if (!rst_in) cyc_cnt <= '0;
    else         cyc_cnt <= cyc_cnt + 32'd1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Read path: one-cycle latency, io_rdata holds until the next read.
  // rx_pop is registered on the sampling edge, so the UART pops the byte that
  // was captured into io_rdata on the following edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      io_rdata <= 8'h00;
      rx_pop   <= 1'b0;
`ifdef IO_CYCLE_COUNTER_EN
      cyc_snap <= '0;
`endif
    end else begin
      rx_pop <= rd_data & ~rx_empty;
      if (rd_any) begin
        io_rdata <= 8'h00;
        if (rd_data && !rx_empty) io_rdata <= rx_data;
`ifdef IO_CYCLE_COUNTER_EN
        // Offset 4 takes a fresh snapshot; 5..7 read the held one so a
        // multi-byte read sees a coherent 32-bit value.
        if (req.off == IO_OFF_STOP) begin
          cyc_snap <= cyc_cnt;
          io_rdata <= cyc_cnt[7:0];
        end else if (req.off[2]) begin
          io_rdata <= snap_byte(cyc_snap, req.off[1:0]);
        end
`endif
      end
    end
  end

endmodule
